// File: rtl/npu_pkg.sv
// NPU shared constants: frame geometry, bus selectors, control bits.
// Also holds the image loader state enum and the bus address helper.
package npu_pkg;

  localparam int IMG_H    = 16;
  localparam int IMG_W    = 15;
  localparam int IMG_SIZE = IMG_H * IMG_W;

  localparam logic [2:0] SEL_IMG   = 3'b001;
  localparam logic [2:0] SEL_WCONV = 3'b010;
  localparam logic [2:0] SEL_FC1W  = 3'b011;
  localparam logic [2:0] SEL_FC2W  = 3'b100;
  localparam logic [2:0] SEL_CTRL  = 3'b101;
  localparam logic [2:0] SEL_STAT  = 3'b110;

  localparam int CTRL_TRIG       = 0;
  localparam int CTRL_SAVE_DONE  = 2;
  localparam int CTRL_NEXT_LAYER = 3;

  typedef enum logic [1:0] {
    COLLECT,
    WRITE,
    TRIG,
    DONE
  } ld_state_e;

  function automatic logic [15:0] npu_addr(
    input logic [2:0]  sel,
    input logic [11:0] idx
  );
    return {1'b0, sel, idx};
  endfunction

endpackage

// File: rtl/npu_img_loader_if.sv
// Pixel stream (s_valid/s_ready/s_data/s_last) plus NPU write port.
// slave = loader side, master = camera/host and NPU side.
interface npu_img_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        ena;
  logic        wea;
  logic [15:0] addra;
  logic [31:0] dina;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, ena, wea, addra, dina
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, ena, wea, addra, dina
  );
endinterface

// File: rtl/npu_byte_packer.sv
// Packs bytes little-endian into a 32-bit word; lane 0 = word_o[7:0].
// Ports: push_i/data_i load a lane, clr_word_i/clr_all_i clear, word_o/lane_o.
module npu_byte_packer (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  input  logic        clr_word_i,
  input  logic        clr_all_i,
  output logic [31:0] word_o,
  output logic [1:0]  lane_o
);

  logic [31:0] buf_q, buf_d;
  logic [1:0]  lane_q, lane_d;

  // Buffer is zeroed after every write, so unfilled lanes read 0.
  always_comb begin
    buf_d  = buf_q;
    lane_d = lane_q;
    if (clr_all_i) begin
      buf_d  = '0;
      lane_d = '0;
    end else if (clr_word_i) begin
      buf_d = '0;
    end else if (push_i) begin
      buf_d[8*lane_q +: 8] = data_i;
      lane_d = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q  <= '0;
      lane_q <= '0;
    end else begin
      buf_q  <= buf_d;
      lane_q <= lane_d;
    end
  end

  assign word_o = buf_q;
  assign lane_o = lane_q;

endmodule

// File: rtl/npu_img_loader.sv
// Streams 8-bit pixels into NPU image words; flags frame length errors.
// Ports: clk, rst_ni, bus (slave), err_clr, done, err_len. Macro NPU_LOADER_AUTO_TRIG_EN.
module npu_img_loader #(
  parameter int         IMG_SIZE = npu_pkg::IMG_SIZE,
  parameter logic [2:0] SEL_IMG  = npu_pkg::SEL_IMG,
  parameter logic [2:0] SEL_CTRL = npu_pkg::SEL_CTRL
) (
  input  logic              clk,
  input  logic              rst_ni,
  npu_img_loader_if.slave   bus,
  input  logic              err_clr,
  output logic              done,
  output logic              err_len
);
  import npu_pkg::*;

  localparam int CW = $clog2(IMG_SIZE + 1);

  ld_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_m1;
  logic        rdy_q;
  logic        end_q, end_d;
  logic        err_q, err_d;
  logic [15:0] addr_q, addr_o;
  logic [31:0] dat_q, dat_o;
  logic        ena_o;
  logic        push, clr_word, clr_all;
  logic        accept, last_pix, ends;
  logic [31:0] word;
  logic [1:0]  lane;
`ifdef NPU_LOADER_AUTO_TRIG_EN
  logic        short_q, short_d;
`endif

  npu_byte_packer u_pack (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .data_i     (bus.s_data),
    .clr_word_i (clr_word),
    .clr_all_i  (clr_all),
    .word_o     (word),
    .lane_o     (lane)
  );

  assign accept   = bus.s_valid & bus.s_ready;
  assign last_pix = (cnt_q == CW'(IMG_SIZE - 1));
  assign ends     = bus.s_last | last_pix;
  assign cnt_m1   = cnt_q - CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    end_d       = end_q;
    err_d       = err_clr ? 1'b0 : err_q;
    ena_o       = 1'b0;
    addr_o      = addr_q;
    dat_o       = dat_q;
    bus.s_ready = 1'b0;
    done        = 1'b0;
    push        = 1'b0;
    clr_word    = 1'b0;
    clr_all     = 1'b0;
`ifdef NPU_LOADER_AUTO_TRIG_EN
    short_d     = short_q;
`endif
    unique case (state_q)
      COLLECT: begin
        bus.s_ready = rdy_q;
        if (accept) begin
          push  = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (ends) begin
            end_d = 1'b1;
`ifdef NPU_LOADER_AUTO_TRIG_EN
            short_d = bus.s_last & ~last_pix;
`endif
          end
          // short (s_last early) or long (no s_last at end)
          if (bus.s_last != last_pix) err_d = 1'b1;
          if (lane == 2'd3 || ends) state_d = WRITE;
        end
      end
      WRITE: begin
        ena_o    = 1'b1;
        addr_o   = npu_addr(SEL_IMG, 12'(cnt_m1 >> 2));
        dat_o    = word;
        clr_word = 1'b1;
        state_d  = COLLECT;
`ifdef NPU_LOADER_AUTO_TRIG_EN
        if (end_q) state_d = short_q ? DONE : TRIG;
`else
        if (end_q) state_d = DONE;
`endif
      end
      TRIG: begin
        ena_o   = 1'b1;
        addr_o  = npu_addr(SEL_CTRL, 12'd0);
        dat_o   = 32'd1 << CTRL_TRIG;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        clr_all = 1'b1;
        cnt_d   = '0;
        end_d   = 1'b0;
`ifdef NPU_LOADER_AUTO_TRIG_EN
        short_d = 1'b0;
`endif
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
`ifdef NPU_LOADER_AUTO_TRIG_EN
      short_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
      end_q   <= end_d;
      err_q   <= err_d;
      addr_q  <= addr_o;
      dat_q   <= dat_o;
`ifdef NPU_LOADER_AUTO_TRIG_EN
      short_q <= short_d;
`endif
    end
  end

  assign bus.ena   = ena_o;
  assign bus.wea   = ena_o;
  assign bus.addra = addr_o;
  assign bus.dina  = dat_o;
  assign err_len   = err_q;

endmodule

// File: doc/npu_img_loader.md
Name: npu_img_loader

Overview:
- Upstream feeder for the NPU host port; sits between the camera/host pixel stream and the NPU's ena/wea/addra/dina write interface.
- Accepts 8-bit pixels over a valid/ready stream and packs them little-endian into 32-bit words.
- Writes each packed word into the NPU image region, one bus write per word.
- On frame completion, optionally issues the conv1 trigger write and pulses done; flags length errors.

Parameters:
- IMG_SIZE, 240, pixels per frame (16x15); need not be a multiple of 4.
- SEL_IMG, 3'b001, addra[14:12] selector for the image buffer.
- SEL_CTRL, 3'b101, addra[14:12] selector for the control/trigger register.

Ports:
- clk  in  1  single clock, rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- s_valid  in  1  pixel valid.
- s_ready  out  1  loader can accept a pixel.
- s_data  in  8  pixel value, unsigned.
- s_last  in  1  marks last pixel of frame.
- err_clr  in  1  clears err_len.
- ena  out  1  NPU port enable.
- wea  out  1  NPU port write enable.
- addra  out  16  {1'b0, sel[2:0], idx[11:0]}.
- dina  out  32  write data.
- done  out  1  one-cycle pulse at frame end.
- err_len  out  1  sticky frame-length error.

Behaviour:
- Reset (async, rst_ni=0) values:
  - s_ready=0, ena=0, wea=0, addra=0, dina=0, done=0, err_len=0.
  - Pixel counter, byte lane, word buffer and state are all cleared; state=COLLECT.
  - s_ready rises on the first clock after release.
  - Reset mid-frame discards the partial word; no write is issued.
- FSM states: COLLECT, WRITE, TRIG, DONE.
- COLLECT:
  - s_ready=1. On s_valid&s_ready, store s_data in lane pix_cnt[1:0] (lane 0 = dina[7:0]) and increment pix_cnt.
  - If the lane was 3, or the pixel was frame-ending, go to WRITE next cycle.
- WRITE (exactly 1 cycle):
  - s_ready=0, ena=1, wea=1, addra={1'b0,SEL_IMG,word_idx}, dina=word buffer.
  - Lanes not filled in the current word are driven 0.
  - word_idx = (pix_cnt-1)>>2, i.e. the index of the word just completed.
  - Word buffer clears after the write.
  - Next state: if the frame ended, go to TRIG (macro defined and frame good) or DONE; otherwise go to COLLECT.
- Frame end: pixel IMG_SIZE-1 accepted, or s_last accepted, whichever comes first.
  - s_last on pixel < IMG_SIZE-1: short frame; flush the partial word zero-padded, set err_len, skip TRIG.
  - Pixel IMG_SIZE-1 accepted with s_last=0: long frame; set err_len, frame completes normally (trigger allowed). Following pixels start a new frame.
- TRIG (1 cycle): ena=1, wea=1, addra={1'b0,SEL_CTRL,12'd0}, dina=32'h1 (trigger bit 0 only).
- DONE (1 cycle):
  - done=1, s_ready=0.
  - pix_cnt, lane and buffer are cleared; return to COLLECT.
- In all cycles other than WRITE/TRIG: ena=wea=0 and addra/dina hold their last value.
- Throughput: 4 pixels per 5 cycles; minimum frame latency from last pixel to done is 2 cycles (3 with TRIG).
- err_len:
  - Sticky; cleared only by err_clr or reset.
  - If err_clr and a new error occur in the same cycle, set wins.
- Widths: pix_cnt is $clog2(IMG_SIZE+1) bits; idx is zero-extended to 12 bits.

Optional Feature:
- Macro NPU_LOADER_AUTO_TRIG_EN.
- Defined: TRIG state exists; after a good frame (no short-frame error), the trigger write is issued before DONE.
- Undefined: TRIG is removed and WRITE goes straight to DONE; the host issues the trigger itself.

Decomposition:
- Shared package npu_pkg holds:
  - IMG_H=16, IMG_W=15, IMG_SIZE.
  - Selector constants SEL_IMG, SEL_WCONV, SEL_FC1W, SEL_FC2W, SEL_CTRL, SEL_STAT.
  - Control bit positions: TRIG=0, SAVE_DONE=2, NEXT_LAYER=3.
  - The loader state enum.
- One natural sub-module, npu_byte_packer: lane counter, 32-bit buffer, clear, zero-pad.

Test Plan:
- 240 pixels with values 0..239, s_last on the last one, s_valid held high:
  - 60 writes at idx 0..59, idx 0 dina=32'h03020100, idx 59 dina=32'hEFEEEDEC.
  - With the macro: trigger write at addra=16'h5000, dina=1.
  - done pulses; err_len=0.
- Short frame: 6 pixels AA..AF with s_last on the 6th:
  - Writes at 16'h1000 with 32'hADACABAA and at 16'h1001 with 32'h0000AFAE.
  - err_len=1; no trigger write; done pulses.
- Long frame: 241 pixels with s_last on the 241st:
  - After pixel 240, err_len=1, 60 writes, done pulses.
  - Pixel 241 is held in lane 0 of a new frame.
- Random s_valid gaps (50%) on a 240-pixel frame: same write data as test 1; no write occurs while s_ready=0 stalls the stream.
- Reset asserted after 10 pixels, then a full clean frame:
  - All outputs read 0 during reset.
  - The next frame's idx 0 holds its own pixels 0..3, with no stale data.
- err_clr while err_len=1 with no new error: err_len drops the next cycle.
